// File: rtl/ir_button_tx.sv
// IR button-code transmitter: idle-high line, low start pulse, three data bits MSB first,
// then a high gap before the frame is reported done.
module ir_button_tx #(
  parameter int unsigned START_LEN = 8,
  parameter int unsigned BIT_LEN   = 14,
  parameter int unsigned GAP_LEN   = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [2:0] code,
  output logic       irda,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CODE_W = 3;
  localparam int unsigned IDX_W  = 2;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(CODE_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BIT   = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                irda_q, irda_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                code_ok_c;

  // Only the five assigned button codes may be transmitted.
  always_comb begin
    code_ok_c = 1'b0;
    case (code)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b110: code_ok_c = 1'b1;
      default:                                code_ok_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= IDX_MSB;
      code_q  <= '0;
      irda_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      irda_q  <= irda_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic; every line value is decided one cycle ahead.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    code_d  = code_q;
    irda_d  = irda_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (send) begin
          if (code_ok_c) begin
            code_d  = code;
            state_d = START;
            irda_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      START: begin
        if (cnt_q == START_LAST) begin
          state_d = BIT;
          cnt_d   = '0;
          idx_d   = IDX_MSB;
          irda_d  = code_q[IDX_MSB];
        end
      end

      BIT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (idx_q != '0) begin
            idx_d  = idx_q - IDX_W'(1);
            irda_d = code_q[idx_q - IDX_W'(1)];
          end else begin
            state_d = GAP;
            irda_d  = 1'b1;
          end
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        irda_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign irda = irda_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
